qtps_decode_stage: RTL

Registered, flow-controlled decode stage for the QTP-S scalar pipe, sitting between instruction queue IQ0 and the ALU/issue stage. It decodes one 32-bit instruction per cycle into a registered micro-op, parametrised in data width and register count. Unlike a purely combinational decoder it holds valid/ready handshakes on both sides, tracks in-flight destination registers in a scoreboard to stall RAW/WAW hazards, and runs a RUN/HALTED/FAULT control FSM.

---
 rtl/qtpa_pkg.sv | 112 +++++++++++
 rtl/qtps_decode_stage_scoreboard.sv | 64 ++++++
 rtl/qtps_decode_stage.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/qtpa_pkg.sv
// Shared QTP-S types: opcodes, instruction formats, decoded micro-op and decode-stage FSM states.
package qtpa_pkg;

  typedef enum logic [5:0] {
    OP_NOP       = 6'h00,
    OP_ADD_IMM   = 6'h01,
    OP_SUB_IMM   = 6'h02,
    OP_SHL_IMM   = 6'h03,
    OP_SHR_IMM   = 6'h04,
    OP_MOV_IMM   = 6'h05,
    OP_CMP_IMM   = 6'h06,
    OP_LCSET_IMM = 6'h07,
    OP_ADD_REG   = 6'h10,
    OP_SUB_REG   = 6'h11,
    OP_SHL_REG   = 6'h12,
    OP_SHR_REG   = 6'h13,
    OP_MOV_REG   = 6'h14,
    OP_CMP_REG   = 6'h15,
    OP_LCSET_REG = 6'h16,
    OP_BRANCH    = 6'h20,
    OP_LOOP      = 6'h21,
    OP_HALT      = 6'h22,
    OP_YIELD     = 6'h23
  } op_t;

  typedef struct packed {
    op_t         opcode;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [17:0] imm18;
  } instr_si_t;

  typedef struct packed {
    op_t         opcode;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [13:0] rsvd;
  } instr_sr_t;

  typedef struct packed {
    op_t         opcode;
    logic [3:0]  rsvd;
    logic [3:0]  rs1;
    logic [17:0] imm18;
  } instr_c_t;

  typedef struct packed {
    op_t         op;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [3:0]  rd;
    logic        we;
    logic        use_imm;
    logic        illegal;
    logic        chk_rs1;
    logic        chk_rs2;
    logic [17:0] imm18;
  } dec_uop_t;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_FAULT  = 2'd2
  } dec_state_t;

  // chk_rs1/chk_rs2 mark which source fields take part in the RAW hazard query.
  function automatic dec_uop_t decode(input logic [31:0] instr);
    instr_si_t si;
    instr_sr_t sr;
    instr_c_t  c;
    dec_uop_t  u;
    si = instr_si_t'(instr);
    sr = instr_sr_t'(instr);
    c  = instr_c_t'(instr);
    u  = '0;
    case (si.opcode)
      OP_ADD_IMM, OP_SUB_IMM, OP_SHL_IMM, OP_SHR_IMM,
      OP_MOV_IMM, OP_CMP_IMM, OP_LCSET_IMM: begin
        u.op      = si.opcode;
        u.rs1     = si.rs1;
        u.rd      = si.rd;
        u.imm18   = si.imm18;
        u.use_imm = 1'b1;
        u.chk_rs1 = 1'b1;
        u.we      = !(si.opcode inside {OP_CMP_IMM, OP_LCSET_IMM});
      end
      OP_ADD_REG, OP_SUB_REG, OP_SHL_REG, OP_SHR_REG,
      OP_MOV_REG, OP_CMP_REG, OP_LCSET_REG: begin
        u.op      = sr.opcode;
        u.rs1     = sr.rs1;
        u.rs2     = sr.rs2;
        u.rd      = sr.rd;
        u.chk_rs1 = 1'b1;
        u.chk_rs2 = 1'b1;
        u.we      = !(sr.opcode inside {OP_CMP_REG, OP_LCSET_REG});
      end
      OP_BRANCH, OP_LOOP, OP_HALT, OP_YIELD, OP_NOP: begin
        u.op      = c.opcode;
        u.rs1     = c.rs1;
        u.imm18   = c.imm18;
        u.use_imm = 1'b1;
        u.chk_rs1 = (c.opcode inside {OP_BRANCH, OP_LOOP});
      end
      default: begin
        u.illegal = 1'b1;
      end
    endcase
    return u;
  endfunction

endpackage

// File: rtl/qtps_decode_stage_scoreboard.sv
// In-flight destination tracker: per-register pending bits with writeback bypass on the hazard query.
module qtps_scoreboard #(
  parameter int  NUM_REGS = 16,
  localparam int REG_AW   = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                set_en,
  input  logic [REG_AW-1:0]   set_idx,
  input  logic                clr_en,
  input  logic [REG_AW-1:0]   clr_idx,
  input  logic                chk_rs1_en,
  input  logic [REG_AW-1:0]   chk_rs1,
  input  logic                chk_rs2_en,
  input  logic [REG_AW-1:0]   chk_rs2,
  input  logic                chk_rd_en,
  input  logic [REG_AW-1:0]   chk_rd,
  output logic                hazard,
  output logic [NUM_REGS-1:0] pending
);

  logic [NUM_REGS-1:0] pend_r;
  logic [NUM_REGS-1:0] busy_s;
  logic [NUM_REGS-1:0] set_mask_s;

  // Pending bits with this cycle's writeback already removed.
  always_comb begin
    busy_s = pend_r;
    if (clr_en) begin
      busy_s[clr_idx] = 1'b0;
    end else begin
      busy_s = pend_r;
    end
  end

  // One-hot of the destination being claimed by the accepted instruction.
  always_comb begin
    set_mask_s = {NUM_REGS{1'b0}};
    if (set_en) begin
      set_mask_s[set_idx] = 1'b1;
    end else begin
      set_mask_s = {NUM_REGS{1'b0}};
    end
  end

  assign hazard = (chk_rs1_en && busy_s[chk_rs1]) ||
                  (chk_rs2_en && busy_s[chk_rs2]) ||
                  (chk_rd_en  && busy_s[chk_rd]);

  // OR-ing the set mask after the clear makes a same-register set win.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_r <= {NUM_REGS{1'b0}};
    end else if (flush) begin
      pend_r <= {NUM_REGS{1'b0}};
    end else begin
      pend_r <= busy_s | set_mask_s;
    end
  end

  assign pending = pend_r;

endmodule

// File: rtl/qtps_decode_stage.sv
// QTP-S decode stage: registered micro-op with valid/ready, RUN/HALTED/FAULT control.
// Define QTPS_DECODE_SCOREBOARD_EN to enable the RAW/WAW scoreboard stall.
module qtps_decode_stage
  import qtpa_pkg::*;
#(
  parameter int  DATA_WIDTH = 32,
  parameter int  NUM_REGS   = 16,
  localparam int REG_AW     = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [31:0]           in_instr,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output op_t                   out_op,
  output logic [REG_AW-1:0]     out_rs1,
  output logic [REG_AW-1:0]     out_rs2,
  output logic [REG_AW-1:0]     out_rd,
  output logic                  out_we,
  output logic                  out_use_imm,
  output logic                  out_illegal,
  output logic [DATA_WIDTH-1:0] out_imm,
  input  logic                  wb_valid,
  input  logic [REG_AW-1:0]     wb_rd,
  input  logic                  flush,
  input  logic                  resume,
  output logic                  halted,
  output logic                  fault,
  output logic [NUM_REGS-1:0]   pending
);

  dec_uop_t   dec_s;
  dec_state_t state_r;
  logic       hazard_s;
  logic       fire_in_s;

  assign dec_s     = decode(in_instr);
  assign in_ready  = (state_r == ST_RUN) && !flush && !hazard_s && (!out_valid || out_ready);
  assign fire_in_s = in_valid && in_ready;

`ifdef QTPS_DECODE_SCOREBOARD_EN
  qtps_scoreboard #(.NUM_REGS(NUM_REGS)) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .set_en     (fire_in_s && dec_s.we),
    .set_idx    (dec_s.rd[REG_AW-1:0]),
    .clr_en     (wb_valid),
    .clr_idx    (wb_rd),
    .chk_rs1_en (dec_s.chk_rs1),
    .chk_rs1    (dec_s.rs1[REG_AW-1:0]),
    .chk_rs2_en (dec_s.chk_rs2),
    .chk_rs2    (dec_s.rs2[REG_AW-1:0]),
    .chk_rd_en  (dec_s.we),
    .chk_rd     (dec_s.rd[REG_AW-1:0]),
    .hazard     (hazard_s),
    .pending    (pending)
  );
`else
  logic unused_s;
  assign hazard_s = 1'b0;
  assign pending  = {NUM_REGS{1'b0}};
  assign unused_s = ^{wb_valid, wb_rd, dec_s.chk_rs1, dec_s.chk_rs2};
`endif

  // Micro-op register: load on accept, hold while stalled, drop valid once drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_op      <= OP_NOP;
      out_rs1     <= {REG_AW{1'b0}};
      out_rs2     <= {REG_AW{1'b0}};
      out_rd      <= {REG_AW{1'b0}};
      out_we      <= 1'b0;
      out_use_imm <= 1'b0;
      out_illegal <= 1'b0;
      out_imm     <= {DATA_WIDTH{1'b0}};
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (fire_in_s) begin
      out_valid   <= 1'b1;
      out_op      <= dec_s.op;
      out_rs1     <= dec_s.rs1[REG_AW-1:0];
      out_rs2     <= dec_s.rs2[REG_AW-1:0];
      out_rd      <= dec_s.rd[REG_AW-1:0];
      out_we      <= dec_s.we;
      out_use_imm <= dec_s.use_imm;
      out_illegal <= dec_s.illegal;
      out_imm     <= {{(DATA_WIDTH-18){dec_s.imm18[17]}}, dec_s.imm18};
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

  // Control FSM; illegal micro-ops decode as NOP so the HALT test cannot alias them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_RUN;
      halted  <= 1'b0;
      fault   <= 1'b0;
    end else if (flush) begin
      state_r <= ST_RUN;
      halted  <= 1'b0;
      fault   <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (fire_in_s && dec_s.illegal) begin
            state_r <= ST_FAULT;
            fault   <= 1'b1;
          end else if (fire_in_s && (dec_s.op == OP_HALT)) begin
            state_r <= ST_HALTED;
            halted  <= 1'b1;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_HALTED: begin
          if (resume) begin
            state_r <= ST_RUN;
            halted  <= 1'b0;
          end else begin
            state_r <= ST_HALTED;
          end
        end
        ST_FAULT: begin
          state_r <= ST_FAULT;
        end
        default: begin
          state_r <= ST_RUN;
          halted  <= 1'b0;
          fault   <= 1'b0;
        end
      endcase
    end
  end

endmodule
